// File: rtl/shared_reg_pkg.sv
// Shared definitions for the shared-register write arbiter: index width helper,
// FSM state encoding and default parameter values.
package shared_reg_pkg;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_WID   = 8;

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } shreg_state_e;

    // Width of a requester index; at least one bit so N_REQ=1 would still elaborate
    function automatic int unsigned IDX_W(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/base_reg.sv
// Enable-loaded storage register with asynchronous active-low reset to zero.
module base_reg #(
    parameter int unsigned WID = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [WID-1:0] data_in,
    output logic [WID-1:0] data_out
);

    // Load on enable, clear on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (en) begin
            data_out <= data_in;
        end
    end

endmodule

// File: rtl/shared_reg_arb_rr_sel.sv
// Combinational rotate-priority selector: picks the first set request bit starting
// at ptr and wrapping, returning a one-hot grant plus its index.
module rr_sel #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx,
    output logic             any
);

    logic [IW-1:0] cand;

    // Scan ptr, ptr+1, ... with wrap; first hit wins
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IW'((32'(ptr) + k) % N_REQ);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arb.sv
// Round-robin write arbiter in front of one shared base_reg. Reports the last
// writer and pulses wr_pulse the cycle after each write lands.
// Optional feature: define SHREG_LOCK_EN to add req_lock and the ARB/LOCKED FSM
// that lets one requester hold exclusive ownership of the register.
module shared_reg_arb
    import shared_reg_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WID   = DEF_WID
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic [N_REQ-1:0]          req_vld,
    input  logic [N_REQ*WID-1:0]      req_data,
`ifdef SHREG_LOCK_EN
    input  logic [N_REQ-1:0]          req_lock,
`endif
    output logic [N_REQ-1:0]          req_rdy,
    output logic [WID-1:0]            data_out,
    output logic                      data_vld,
    output logic                      wr_pulse,
    output logic [IDX_W(N_REQ)-1:0]   wr_src
);

    localparam int unsigned IW = IDX_W(N_REQ);

    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    g_idx;
    logic [N_REQ-1:0] req_eff, gnt;
    logic             g_any, transfer;
    logic [WID-1:0]   mux_data, reg_din;
    logic             reg_en;
    logic             vld_q, pulse_q;
    logic [IW-1:0]    src_q;

    function automatic logic [IW-1:0] nxt_idx(input logic [IW-1:0] i);
        return (i == IW'(N_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

`ifdef SHREG_LOCK_EN
    shreg_state_e  state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          owner_drop;

    // While locked, only the owner's request is visible to the selector
    always_comb begin
        req_eff = req_vld;
        if (state_q == ST_LOCKED) begin
            req_eff = req_vld & (N_REQ'(1) << owner_q);
        end
    end

    assign owner_drop = (state_q == ST_LOCKED) && !req_vld[owner_q] && !clr;

    // Lock FSM next state; clr freezes it so a lock survives a clear
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            ST_ARB: begin
                if (transfer && req_lock[g_idx]) begin
                    state_d = ST_LOCKED;
                    owner_d = g_idx;
                end
            end
            ST_LOCKED: begin
                if ((transfer && !req_lock[g_idx]) || owner_drop) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Lock FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ARB;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end
`else
    assign req_eff = req_vld;
`endif

    rr_sel #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_sel (
        .req (req_eff),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (g_idx),
        .any (g_any)
    );

    assign req_rdy  = clr ? '0 : gnt;
    assign transfer = g_any && !clr;
    assign mux_data = req_data[32'(g_idx) * WID +: WID];
    assign reg_en   = transfer || clr;
    assign reg_din  = clr ? '0 : mux_data;

    // Pointer advances past the last writer; a dropped lock resumes after the owner
    always_comb begin
        ptr_d = ptr_q;
        if (transfer) begin
            ptr_d = nxt_idx(g_idx);
        end
`ifdef SHREG_LOCK_EN
        else if (owner_drop) begin
            ptr_d = nxt_idx(owner_q);
        end
`endif
    end

    // Pointer and status flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            vld_q   <= 1'b0;
            pulse_q <= 1'b0;
            src_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            pulse_q <= transfer;
            if (clr) begin
                vld_q <= 1'b0;
            end else if (transfer) begin
                vld_q <= 1'b1;
                src_q <= g_idx;
            end
        end
    end

    base_reg #(
        .WID (WID)
    ) u_base_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (reg_en),
        .data_in  (reg_din),
        .data_out (data_out)
    );

    assign data_vld = vld_q;
    assign wr_pulse = pulse_q;
    assign wr_src   = src_q;

endmodule

// File: tb/tb_shared_reg_arb.sv
// Self-checking bench for shared_reg_arb: directed steps followed by random traffic,
// checked against a behavioural model of the arbitration rules.
module tb_shared_reg_arb;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           clr;
    logic [N-1:0]   req_vld;
    logic [N*W-1:0] req_data;
`ifdef SHREG_LOCK_EN
    logic [N-1:0]   req_lock;
`endif
    logic [N-1:0]   req_rdy;
    logic [W-1:0]   data_out;
    logic           data_vld;
    logic           wr_pulse;
    logic [1:0]     wr_src;

    shared_reg_arb #(
        .N_REQ (N),
        .WID   (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .req_vld  (req_vld),
        .req_data (req_data),
`ifdef SHREG_LOCK_EN
        .req_lock (req_lock),
`endif
        .req_rdy  (req_rdy),
        .data_out (data_out),
        .data_vld (data_vld),
        .wr_pulse (wr_pulse),
        .wr_src   (wr_src)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int       m_ptr;
    logic [W-1:0] m_data;
    bit       m_vld;
    bit       m_pulse;
    int       m_src;
    bit       m_locked;
    int       m_owner;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_data = '0; m_vld = 0; m_pulse = 0; m_src = 0;
        m_locked = 0; m_owner = 0;
    endtask

    // Who should be granted right now, or -1
    function automatic int exp_grant();
        if (clr) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (m_locked && i != m_owner) continue;
            if (req_vld[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input int g);
        if (clr) begin
            m_data = '0; m_vld = 0; m_pulse = 0;
        end else if (g >= 0) begin
            m_data  = req_data[g*W +: W];
            m_src   = g;
            m_vld   = 1;
            m_pulse = 1;
            m_ptr   = (g + 1) % N;
`ifdef SHREG_LOCK_EN
            if (!m_locked && req_lock[g]) begin
                m_locked = 1; m_owner = g;
            end else if (m_locked && !req_lock[g]) begin
                m_locked = 0;
            end
`endif
        end else begin
            m_pulse = 0;
            if (m_locked && !req_vld[m_owner]) begin
                m_locked = 0;
                m_ptr = (m_owner + 1) % N;
            end
        end
    endtask

    // One clock: inputs already driven after negedge
    task automatic cycle(input string tag);
        int g;
        logic [N-1:0] eg;
        #1;
        g  = exp_grant();
        eg = (g >= 0) ? N'(1) << g : '0;
        check({tag, ".rdy"}, 32'(req_rdy), 32'(eg));
        @(posedge clk);
        model_step(g);
        #1;
        check({tag, ".data"},  32'(data_out), 32'(m_data));
        check({tag, ".vld"},   32'(data_vld), 32'(m_vld));
        check({tag, ".pulse"}, 32'(wr_pulse), 32'(m_pulse));
        check({tag, ".src"},   32'(wr_src),   32'(m_src));
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        clr = 0; req_vld = '0; req_data = '0;
`ifdef SHREG_LOCK_EN
        req_lock = '0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        #1;
        model_reset();
        check("rst.data",  32'(data_out), 32'(0));
        check("rst.vld",   32'(data_vld), 32'(0));
        check("rst.pulse", 32'(wr_pulse), 32'(0));
        check("rst.rdy",   32'(req_rdy),  32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // Reset asserted between clock edges, while traffic is live
    task automatic async_reset(input string tag);
        #2 rst_n = 0;
        #1;
        model_reset();
        check({tag, ".data"},  32'(data_out), 32'(0));
        check({tag, ".vld"},   32'(data_vld), 32'(0));
        check({tag, ".pulse"}, 32'(wr_pulse), 32'(0));
        check({tag, ".src"},   32'(wr_src),   32'(0));
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0;
        idle_inputs();
        model_reset();
        @(negedge clk);

        // 1. Reset and idle
        do_reset();
        repeat (10) cycle("idle");

        // 2. Single requester
        req_vld  = 4'b0100;
        req_data = {$urandom};
        req_data[2*W +: W] = 8'hA5;
        #1 check("single.rdy_direct", 32'(req_rdy), 32'(4'b0100));
        cycle("single");
        check("single.data_direct", 32'(data_out), 32'hA5);
        check("single.src_direct",  32'(wr_src),   32'd2);
        req_vld = '0;
        cycle("single_idle");

        // 3. All requesting from a fresh pointer: strict rotation
        do_reset();
        req_vld = 4'hF;
        for (int k = 0; k < 8; k++) begin
            req_data = {$urandom};
            cycle("all");
            check("all.order", 32'(wr_src), 32'(k % N));
        end

        // 4. Clear with a pending request
        req_vld = 4'b0001;
        clr     = 1;
        cycle("clr");
        check("clr.data_direct", 32'(data_out), 32'(0));
        clr = 0;
        cycle("after_clr");
        check("after_clr.src_direct", 32'(wr_src), 32'd0);

        // 5. Wrap: move ptr to 3, then request 3 and 0
        req_vld = 4'b0100;
        cycle("wrap_setup");
        req_vld = 4'b1001;
        cycle("wrap_a");
        check("wrap.first", 32'(wr_src), 32'd3);
        cycle("wrap_b");
        check("wrap.second", 32'(wr_src), 32'd0);
        req_vld = 4'hF;
        #1 check("wrap.ptr1", 32'(req_rdy), 32'(4'b0010));
        cycle("wrap_ptr");

`ifdef SHREG_LOCK_EN
        // 6. Lock by requester 1 with everyone requesting
        do_reset();
        req_vld = 4'b0001;
        cycle("lock_setup");
        req_vld  = 4'hF;
        req_lock = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            req_data = {$urandom};
            cycle("locked");
            check("locked.src", 32'(wr_src), 32'd1);
        end
        req_lock = '0;
        cycle("unlock");
        cycle("after_unlock");
        check("after_unlock.src", 32'(wr_src), 32'd2);
        req_lock = 4'b1000;
        cycle("relock");
        async_reset("lock_arst");
        req_lock = '0;
        req_vld  = 4'hF;
        cycle("post_arst");
        check("post_arst.src", 32'(wr_src), 32'd0);
`endif

        // Random traffic with occasional clears and mid-cycle resets
        do_reset();
        for (int n = 0; n < 400; n++) begin
            req_vld  = N'($urandom);
            req_data = {$urandom};
            clr      = ($urandom_range(0, 7) == 0);
`ifdef SHREG_LOCK_EN
            req_lock = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
`endif
            cycle("rand");
            if ($urandom_range(0, 49) == 0) async_reset("rand_arst");
        end
        async_reset("final_arst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
